onehot_pulse_decoder: RTL and testbench

- Receive side of the 4-to-2 priority-encoded request path. Each accepted 2-bit code (plus its any-request flag) is decoded back to a one-hot line `o[3:0]`.
- Each decoded line is driven as a timed pulse of `PULSE_LEN` cycles, followed by `GAP_LEN` idle cycles.
- A single-entry pending buffer with a valid/ready handshake lets the upstream queue one code while a pulse is in progress.

---
 rtl/onehot_pulse_decoder.sv | 102 ++++++++++
 tb/tb_onehot_pulse_decoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: decodes accepted 2-bit codes into timed one-hot pulses with a one-deep pending buffer
module onehot_pulse_decoder #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_any,
  output logic [3:0]       o,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t           r_state, w_state_nx;
  logic [7:0]       r_cnt, w_cnt_nx;
  logic [3:0]       r_o, w_o_nx;
  logic             r_any, w_any_nx;
  logic             r_pend_full, w_pend_full_nx;
  logic [1:0]       r_pend_code, w_pend_code_nx;
  logic             r_pend_any, w_pend_any_nx;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic             w_xfer, w_last, w_load, w_fill, w_ld_any;
  logic [1:0]       w_ld_code;
  function automatic logic [3:0] dec(input logic [1:0] c, input logic a);
    return a ? 4'b0001 << c : 4'b0000;
  endfunction
  assign in_ready  = rst_n & ~r_pend_full;
  assign w_xfer    = in_valid & in_ready;
  assign w_last    = r_cnt == 8'd0;
  assign w_ld_code = r_pend_full ? r_pend_code : in_code;
  assign w_ld_any  = r_pend_full ? r_pend_any : in_any;
  assign done      = r_state == PULSE && w_last;
  assign busy      = r_state != IDLE || r_pend_full;
  assign o         = r_o;
  assign pulse_cnt = r_pulse_cnt;
  // A slot ending with nothing pending may take a same-edge transfer directly, keeping back-to-back pulses seamless
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_o_nx         = r_o;
    w_any_nx       = r_any;
    w_pend_full_nx = r_pend_full;
    w_pend_code_nx = r_pend_code;
    w_pend_any_nx  = r_pend_any;
    w_load         = 1'b0;
    w_fill         = 1'b0;
    if (r_state == IDLE) begin
      w_load = w_xfer;
    end else if (!w_last) begin
      w_cnt_nx = r_cnt - 8'd1;
      w_fill   = w_xfer;
    end else if (r_state == PULSE && GAP_LEN > 0) begin
      w_state_nx = GAP;
      w_cnt_nx   = 8'(GAP_LEN - 1);
      w_o_nx     = 4'b0000;
      w_fill     = w_xfer;
    end else if (r_pend_full || w_xfer) begin
      w_load = 1'b1;
    end else begin
      w_state_nx = IDLE;
      w_o_nx     = 4'b0000;
    end
    if (w_load) begin
      w_state_nx     = PULSE;
      w_cnt_nx       = 8'(PULSE_LEN - 1);
      w_o_nx         = dec(w_ld_code, w_ld_any);
      w_any_nx       = w_ld_any;
      w_pend_full_nx = 1'b0;
    end
    if (w_fill) begin
      w_pend_full_nx = 1'b1;
      w_pend_code_nx = in_code;
      w_pend_any_nx  = in_any;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_o         <= 4'b0000;
      r_any       <= 1'b0;
      r_pend_full <= 1'b0;
      r_pend_code <= 2'b00;
      r_pend_any  <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_o         <= w_o_nx;
      r_any       <= w_any_nx;
      r_pend_full <= w_pend_full_nx;
      r_pend_code <= w_pend_code_nx;
      r_pend_any  <= w_pend_any_nx;
      r_pulse_cnt <= (done && r_any && !(&r_pulse_cnt)) ? r_pulse_cnt + 1'b1 : r_pulse_cnt;
    end
  end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: three configurations checked against a slot-timeline model of accepted codes
module tb_onehot_pulse_decoder;
  typedef struct {int start; logic [1:0] code; logic any;} slot_t;
  localparam int P[3] = '{4, 1, 3};
  localparam int G[3] = '{1, 0, 2};
  localparam int W[3] = '{8, 8, 2};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] v = 3'b000;
  logic [1:0] cd[3];
  logic an[3];
  logic rdy0, rdy1, rdy2, dn0, dn1, dn2, bz0, bz1, bz2;
  logic [3:0] o0, o1, o2;
  logic [7:0] pc0, pc1;
  logic [1:0] pc2;
  wire [2:0] rdyv = {rdy2, rdy1, rdy0};
  wire [2:0] dnv = {dn2, dn1, dn0};
  wire [2:0] bzv = {bz2, bz1, bz0};
  wire [2:0][3:0] ov = {o2, o1, o0};
  wire [2:0][7:0] pcv = {{6'b0, pc2}, pc1, pc0};
  int k = 0, checks = 0, errors = 0;
  slot_t q[3][$];
  int fr[3] = '{0, 0, 0};
  logic [2:0] mr = 3'b000, acc = 3'b000;
  always #5 clk = ~clk;
  onehot_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(v[0]),
    .in_ready(rdy0), .in_code(cd[0]), .in_any(an[0]), .o(o0), .done(dn0), .busy(bz0), .pulse_cnt(pc0));
  onehot_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v[1]),
    .in_ready(rdy1), .in_code(cd[1]), .in_any(an[1]), .o(o1), .done(dn1), .busy(bz1), .pulse_cnt(pc1));
  onehot_pulse_decoder #(.PULSE_LEN(3), .GAP_LEN(2), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(v[2]),
    .in_ready(rdy2), .in_code(cd[2]), .in_any(an[2]), .o(o2), .done(dn2), .busy(bz2), .pulse_cnt(pc2));
  task automatic chk(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d got=%h exp=%h", tag, i, k, got, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] eo;
      logic ed, pend;
      int nn, mx;
      eo = 4'b0; ed = 1'b0; pend = 1'b0; nn = 0; mx = (1 << W[i]) - 1;
      for (int j = 0; j < q[i].size(); j++) begin
        slot_t s;
        s = q[i][j];
        if (s.start <= k && k < s.start + P[i]) eo = s.any ? 4'(1 << s.code) : 4'b0;
        if (k == s.start + P[i] - 1) ed = 1'b1;
        if (s.any && s.start + P[i] - 1 < k) nn++;
        if (s.start > k) pend = 1'b1;
      end
      mr[i] = rst_n && !pend;
      chk("o", i, 8'(ov[i]), 8'(eo));
      chk("done", i, 8'(dnv[i]), 8'(ed));
      chk("busy", i, 8'(bzv[i]), 8'(k < fr[i] || pend));
      chk("in_ready", i, 8'(rdyv[i]), 8'(mr[i]));
      chk("pulse_cnt", i, pcv[i], 8'(nn > mx ? mx : nn));
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      acc[i] = 1'b0;
      if (!rst_n) begin
        q[i].delete();
        fr[i] = 0;
      end else if (v[i] && mr[i]) begin
        int st;
        st = (k + 1 > fr[i]) ? k + 1 : fr[i];
        q[i].push_back('{st, cd[i], an[i]});
        fr[i] = st + P[i] + G[i];
        acc[i] = 1'b1;
      end
    end
    #1 k++;
  endtask
  task automatic send(input logic [1:0] c, input logic a);
    int n;
    n = 0;
    v = 3'b111;
    for (int i = 0; i < 3; i++) begin cd[i] = c; an[i] = a; end
    while (v != 3'b000 && n < 60) begin
      cycle();
      v = v & ~acc;
      n++;
    end
    chk("send_timeout", 0, 8'(v), 8'd0);
    v = 3'b000;
  endtask
  task automatic idle(input int n);
    v = 3'b000;
    repeat (n) cycle();
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin cd[i] = 2'b00; an[i] = 1'b0; end
    @(posedge clk);
    #1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send(2'b10, 1'b1);
    idle(8);
    send(2'b00, 1'b1);
    send(2'b11, 1'b1);
    send(2'b01, 1'b1);
    idle(20);
    send(2'b01, 1'b1);
    send(2'b01, 1'b1);
    send(2'b01, 1'b1);
    idle(12);
    send(2'b11, 1'b0);
    idle(10);
    send(2'b01, 1'b1);
    send(2'b10, 1'b1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(12);
    repeat (5) send(2'($urandom_range(0, 3)), 1'b1);
    idle(15);
    repeat (1500) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || acc[i]) begin
          v[i] = $urandom_range(0, 2) != 0;
          cd[i] = 2'($urandom_range(0, 3));
          an[i] = $urandom_range(0, 4) != 0;
        end
      end
      rst_n = $urandom_range(0, 199) != 0;
      cycle();
    end
    rst_n = 1'b1;
    idle(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
